// File: rtl/logic_avalon_st_from_axi4_stream_if.sv
// ============================================================================
// Module  : axi4_stream_if / avalon_st_if
// Purpose : AXI4-Stream and Avalon-ST bundles used by the stream bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport rx (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
  modport tx (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
endinterface

interface avalon_st_if #(
  parameter int DATA_BYTES    = 1,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = 1
);
  logic                     valid;
  logic                     ready;
  logic [DATA_BYTES*8-1:0]  data;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [1:0]               error;
  logic [CHANNEL_WIDTH-1:0] channel;

  modport tx (output valid, data, startofpacket, endofpacket, empty, error, channel, input ready);
  modport rx (input valid, data, startofpacket, endofpacket, empty, error, channel, output ready);
endinterface

`default_nettype wire

// File: rtl/logic_avalon_st_from_axi4_stream.sv
// ============================================================================
// Module  : logic_avalon_st_from_axi4_stream
// Purpose : AXI4-Stream to Avalon-ST bridge behind a registered 2-entry skid pipe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_avalon_st_from_axi4_stream #(
  parameter int TDATA_BYTES                     = 1,
  parameter int TID_WIDTH                       = 1,
  parameter int TUSER_WIDTH                     = 1,
  parameter int CHANNEL_WIDTH                   = 1,
  parameter int EMPTY_WIDTH                     = (TDATA_BYTES < 2) ? 1 : $clog2(TDATA_BYTES),
  parameter int USE_TLAST                       = 1,
  parameter int USE_TKEEP                       = 1,
  parameter int FIRST_SYMBOL_IN_HIGH_ORDER_BITS = 1
) (
  input  logic      aclk,
  input  logic      areset_n,
  axi4_stream_if.rx rx,
  avalon_st_if.tx   tx
);

  localparam int DATA_W = TDATA_BYTES * 8;
  localparam int ZERO_W = $clog2(TDATA_BYTES + 1);

  typedef struct packed {
    logic [DATA_W-1:0]        data;
    logic                     sop;
    logic                     eop;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [1:0]               error;
    logic [CHANNEL_WIDTH-1:0] channel;
  } beat_t;

  logic                     out_valid_q, out_valid_d;
  logic                     skid_valid_q, skid_valid_d;
  logic                     in_packet_q, in_packet_d;
  beat_t                    out_beat_q, out_beat_d;
  beat_t                    skid_beat_q, skid_beat_d;
  beat_t                    in_beat;

  logic [TDATA_BYTES-1:0]   keep;
  logic [TDATA_BYTES-1:0]   keep_inc;
  logic [ZERO_W-1:0]        zero_bytes;
  logic [DATA_W-1:0]        mapped_data;
  logic [CHANNEL_WIDTH-1:0] channel;
  logic                     eff_last;
  logic                     contiguous;
  logic                     malformed;
  logic                     accept;
  logic                     drain;
  logic                     unused_ok;

  assign eff_last   = (USE_TLAST != 0) ? rx.tlast : 1'b1;
  assign keep       = (USE_TKEEP != 0) ? rx.tkeep : '1;
  // A valid keep is a run of ones from bit 0; adding one clears it completely.
  assign keep_inc   = keep + TDATA_BYTES'(1);
  assign contiguous = (keep != '0) && ((keep & keep_inc) == '0);
  assign malformed  = eff_last ? !contiguous : (keep != '1);

  generate
    for (genvar k = 0; k < TDATA_BYTES; k++) begin : g_byte_map
      localparam int SRC = (FIRST_SYMBOL_IN_HIGH_ORDER_BITS != 0) ? (TDATA_BYTES - 1 - k) : k;
      assign mapped_data[8*k +: 8] = rx.tdata[8*SRC +: 8];
    end
    if (CHANNEL_WIDTH <= TID_WIDTH) begin : g_chan_trunc
      assign channel = rx.tid[CHANNEL_WIDTH-1:0];
    end else begin : g_chan_ext
      assign channel = {{(CHANNEL_WIDTH - TID_WIDTH){1'b0}}, rx.tid};
    end
  endgenerate

  always_comb begin
    zero_bytes = '0;
    for (int i = 0; i < TDATA_BYTES; i++) begin
      if (!keep[i]) zero_bytes = zero_bytes + 1'b1;
    end
  end

  always_comb begin
    in_beat.data    = mapped_data;
    in_beat.sop     = !in_packet_q;
    in_beat.eop     = eff_last;
    in_beat.empty   = eff_last ? EMPTY_WIDTH'(zero_bytes) : '0;
    in_beat.error   = {malformed, rx.tuser[0]};
    in_beat.channel = channel;
  end

  assign accept = rx.tvalid && !skid_valid_q;
  assign drain  = out_valid_q && tx.ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_beat_d   = out_beat_q;
    skid_valid_d = skid_valid_q;
    skid_beat_d  = skid_beat_q;
    in_packet_d  = in_packet_q;
    if (accept) in_packet_d = !eff_last;
    // The skid entry is only ever occupied while the output register is too.
    if (!out_valid_q || drain) begin
      out_valid_d  = skid_valid_q || accept;
      out_beat_d   = skid_valid_q ? skid_beat_q : in_beat;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_beat_d  = in_beat;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_packet_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_packet_q  <= in_packet_d;
    end
  end

  always_ff @(posedge aclk) begin
    out_beat_q  <= out_beat_d;
    skid_beat_q <= skid_beat_d;
  end

  assign rx.tready        = !skid_valid_q;
  assign tx.valid         = out_valid_q;
  assign tx.data          = out_beat_q.data;
  assign tx.startofpacket = out_beat_q.sop;
  assign tx.endofpacket   = out_beat_q.eop;
  assign tx.empty         = out_beat_q.empty;
  assign tx.error         = out_beat_q.error;
  assign tx.channel       = out_beat_q.channel;

  assign unused_ok = ^{rx.tstrb, rx.tdest, rx.tuser, rx.tid, rx.tlast, rx.tkeep};

endmodule

`default_nettype wire

// File: doc/logic_avalon_st_from_axi4_stream.md
LOGIC_AVALON_ST_FROM_AXI4_STREAM -- requirements
Module: logic_avalon_st_from_axi4_stream

Interface
REQ-001 SHALL have parameter TDATA_BYTES, default 1, bytes per tdata/data beat.
REQ-002 SHALL have parameter TID_WIDTH, default 1, tid bits.
REQ-003 SHALL have parameter TUSER_WIDTH, default 1, tuser bits.
REQ-004 SHALL have parameter CHANNEL_WIDTH, default 1, channel bits.
REQ-005 SHALL have parameter EMPTY_WIDTH, default clog2(TDATA_BYTES) (1 when TDATA_BYTES<2), empty bits.
REQ-006 SHALL have parameter USE_TLAST, default 1; 0 = every beat is a one-beat packet.
REQ-007 SHALL have parameter USE_TKEEP, default 1; 0 = tkeep treated as all ones.
REQ-008 SHALL have parameter FIRST_SYMBOL_IN_HIGH_ORDER_BITS, default 1; 1 = big-endian, 0 = little-endian.
REQ-009 SHALL have port aclk, input, 1, clock.
REQ-010 SHALL have port areset_n, input, 1, reset, asynchronous, active-low.
REQ-011 SHALL have port rx, AXI4-Stream receiver modport, TDATA_BYTES*8 data, AXI4-Stream input.
REQ-012 SHALL have port tx, Avalon-ST source modport, TDATA_BYTES*8 data, readyLatency 0, Avalon-ST output.

Function
REQ-013 SHALL be a 2-entry pipeline: output register plus skid register; full throughput, no combinational path tx.ready -> rx.tready.
REQ-014 SHALL drive rx.tready = NOT skid_valid.
REQ-015 SHALL accept a beat on rx.tvalid AND rx.tready; load output register if empty or draining (tx.valid AND tx.ready), else load skid register.
REQ-016 SHALL move skid register into output register on the cycle the output drains; skid_valid clears then.
REQ-017 SHALL give latency 1 cycle from rx acceptance to tx.valid when the pipeline is empty.
REQ-018 SHALL hold all tx payload stable while tx.valid=1 AND tx.ready=0.
REQ-019 SHALL keep in_packet flag: set on accepted beat with tlast=0, clear on accepted beat with tlast=1; tlast treated as 1 when USE_TLAST=0.
REQ-020 SHALL set startofpacket = NOT in_packet at acceptance; endofpacket = effective tlast.
REQ-021 SHALL map tdata byte k to data byte TDATA_BYTES-1-k when big-endian, else byte k.
REQ-022 SHALL set empty = count of tkeep=0 bytes on endofpacket beats (tkeep contiguous from byte 0); empty = 0 on all other beats and when USE_TKEEP=0.
REQ-023 SHALL set error[0] = tuser[0]; error[1] = malformed keep (non-eop beat with tkeep not all ones, or eop tkeep non-contiguous or all zero); error width 2.
REQ-024 SHALL set channel = tid, zero-extended or truncated to CHANNEL_WIDTH; tdest, tstrb ignored.
REQ-025 SHALL not buffer or drop malformed beats; they pass with error[1]=1.

Reset
REQ-026 SHALL, while areset_n=0, force tx.valid=0, skid_valid=0, in_packet=0 asynchronously; rx.tready=1 during and after reset.
REQ-027 SHALL not reset payload registers; contents undefined until first valid beat.
REQ-028 SHALL discard any beats held in the pipeline on reset; the first beat after reset has startofpacket=1.

Verification
REQ-029 TDATA_BYTES=4, 3-beat packet, tx.ready=1 -> tx.valid 1 cycle after each accept, sop on beat 0 only, eop on beat 2, empty=0 on beats 0-1.
REQ-030 Last beat tkeep=4'b0011 -> empty=2, error=2'b00; tkeep=4'b0101 -> error[1]=1.
REQ-031 tx.ready=0 for 3 cycles during stream -> at most 2 beats buffered, rx.tready=0 after second, no loss, order preserved.
REQ-032 Big-endian, tdata=32'h44332211 -> data=32'h11223344; little-endian -> data=32'h44332211.
REQ-033 areset_n low mid-packet with skid full -> tx.valid=0 immediately, rx.tready=1; next packet beat 0 has startofpacket=1.
REQ-034 USE_TLAST=0, random tvalid/tready -> every output beat sop=eop=1, throughput equals min(source, sink) rate.
